i2s_clkgen_ctrl: RTL and testbench
==================================

Name: i2s_clkgen_ctrl

Overview:
- Master-mode bit-clock/word-select sequencer for the I2S transceiver core.
- Divides the system clock to produce SCK, generates WS framed by the programmed channel length, and starts and stops framing cleanly at frame boundaries.
- Its SCK/WS outputs drive the core's i2s_sck_i/i2s_ws_i in master mode. Strobe outputs let the register/DMA layer track frames.

Parameters:
- DIV_WIDTH, 16, width of the SCK half-period divider.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- en_i  input  1  run request; sampled in IDLE and at each frame boundary.
- div_i  input  DIV_WIDTH  SCK half-period minus 1, in clk_i cycles.
- chl_i  input  2  channel length: 0=8, 1=16, 2=24, 3=32 bits (I2S_DAT_* encoding).
- busy_o  output  1  high whenever not IDLE.
- i2s_sck_o  output  1  generated bit clock, idles low.
- i2s_ws_o  output  1  word select: 0=left, 1=right; idles high.
- sck_re_o  output  1  one-cycle pulse in the cycle i2s_sck_o becomes 1.
- sck_fe_o  output  1  one-cycle pulse in the cycle i2s_sck_o becomes 0.
- frame_done_o  output  1  one-cycle pulse at the falling SCK edge ending the right channel.

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low.
- Reset values: state=IDLE; i2s_sck_o=0; i2s_ws_o=1; busy_o=0; all pulses 0; div_cnt=0; bit_cnt=0.
- A reset assertion mid-frame returns everything to reset values immediately. No drain.
- Registered config: div_q and N=8*(chl_i+1) are latched on IDLE->RUN and at every frame boundary. Changes to div_i/chl_i mid-frame have no effect until the next frame.
- State IDLE: SCK held 0, WS held 1.
  - en_i=1 in cycle t -> RUN in cycle t+1.
  - At t+1: i2s_ws_o=0 (WS falling edge), div_cnt=0, bit_cnt=0.
- State RUN, divider:
  - div_cnt increments each cycle.
  - When div_cnt==div_q: i2s_sck_o toggles in the next cycle, div_cnt<=0, and the matching sck_re_o/sck_fe_o pulse is asserted in that same next cycle.
  - Each SCK half-period is div_q+1 clk_i cycles. div_i=0 gives SCK=clk/2.
  - The first SCK rise after entry is at cycle t+1+div_q+1.
- State RUN, bit and WS sequencing:
  - bit_cnt increments on each SCK falling edge.
  - On the falling edge with bit_cnt==N-1: bit_cnt<=0 and WS toggles. Each channel is exactly N SCK periods, and WS changes only coincident with SCK falling.
- Frame boundary: the falling edge ending the right channel (WS 1->0 transition point). frame_done_o pulses in that cycle.
  - en_i=1: WS toggles to 0, config is relatched, and RUN continues.
  - en_i=0: WS stays 1, SCK stays 0, next state is IDLE.
- Stop semantics:
  - en_i is ignored mid-frame; a deassertion takes effect only at the frame boundary.
  - A low pulse on en_i that returns high before the boundary is ignored.
- Restart: en_i=1 in the IDLE cycle that follows a stop restarts the sequence, beginning with the WS falling edge.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: I2S_CLKGEN_FRM_CNT_EN.
- When defined:
  - Adds output frm_cnt_o [15:0], counting completed frames.
  - Increments with each frame_done_o pulse and wraps 0xFFFF->0.
  - Cleared by reset and on IDLE->RUN.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n_i=0 -> sck=0, ws=1, busy=0, no pulses. Release with en_i=0 -> outputs remain unchanged for 100 cycles.
- Basic framing: div_i=1, chl_i=0, en_i=1 at t.
  - ws_o=0 at t+1; first sck rise at t+3.
  - SCK period 4 clk; WS low for 8 SCK periods (32 clk), then high for 32 clk.
  - frame_done_o at t+65.
- Clean stop: chl_i=1, drop en_i mid-left channel -> framing continues until the right channel's 16th falling edge. Then frame_done_o pulses, WS stays 1, busy_o=0 the next cycle, and no further SCK edges.
- Config latching: div_i changed 1->3 and chl_i 0->3 mid-frame -> current frame still uses 4-clk SCK and 8-bit channels. The next frame uses 8-clk SCK and 32-bit channels.
- Edge cases: div_i=0 -> SCK=clk/2 with sck_re_o/sck_fe_o alternating every cycle. Async reset asserted mid-frame -> outputs return to reset values without waiting for a clk edge.
- Feature on: 5 frames with en_i=1 -> frm_cnt_o=5. Preload 0xFFFF via force, one more frame -> 0. Stop then restart -> frm_cnt_o=0.

Source files
------------

// File: rtl/i2s_clkgen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clkgen_ctrl
//  Purpose  : Master-mode I2S SCK/WS sequencer. Divides clk_i down to SCK,
//             frames WS by the programmed channel length, and starts/stops
//             only at frame boundaries.
//  Options  : I2S_CLKGEN_FRM_CNT_EN adds the frm_cnt_o completed-frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clkgen_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           chl_i,
    output logic                 busy_o,
    output logic                 i2s_sck_o,
    output logic                 i2s_ws_o,
    output logic                 sck_re_o,
    output logic                 sck_fe_o,
    output logic                 frame_done_o
`ifdef I2S_CLKGEN_FRM_CNT_EN
    ,
    output logic [15:0]          frm_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Last bit index of a channel is 8*(chl+1)-1 = {chl, 3'b111}.
    localparam logic [2:0] c_ch_lsbs = 3'b111;

    state_t                 r_state;
    logic [DIV_WIDTH-1:0]   r_div_q;
    logic [1:0]             r_chl_q;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [4:0]             r_bit_cnt;
    logic                   r_sck;
    logic                   r_ws;
    logic                   r_sck_re;
    logic                   r_sck_fe;
    logic                   r_frame_done;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [DIV_WIDTH-1:0]   w_div_q_nxt;
    logic [1:0]             w_chl_q_nxt;
    logic [DIV_WIDTH-1:0]   w_div_cnt_nxt;
    logic [4:0]             w_bit_cnt_nxt;
    logic                   w_sck_nxt;
    logic                   w_ws_nxt;
    logic                   w_sck_re_nxt;
    logic                   w_sck_fe_nxt;
    logic                   w_frame_done_nxt;
    logic                   w_div_hit;
    logic                   w_last_bit;

    assign w_div_hit  = (r_div_cnt == r_div_q);
    assign w_last_bit = (r_bit_cnt == {r_chl_q, c_ch_lsbs});

    always_comb begin
        w_state_nxt      = r_state;
        w_div_q_nxt      = r_div_q;
        w_chl_q_nxt      = r_chl_q;
        w_div_cnt_nxt    = r_div_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_sck_nxt        = r_sck;
        w_ws_nxt         = r_ws;
        w_sck_re_nxt     = 1'b0;
        w_sck_fe_nxt     = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sck_nxt     = 1'b0;
                w_ws_nxt      = 1'b1;
                w_div_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                if (en_i) begin
                    w_state_nxt = ST_RUN;
                    w_ws_nxt    = 1'b0;
                    w_div_q_nxt = div_i;
                    w_chl_q_nxt = chl_i;
                end
            end

            ST_RUN: begin
                if (!w_div_hit) begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end else begin
                    w_div_cnt_nxt = '0;
                    w_sck_nxt     = ~r_sck;
                    if (!r_sck) begin
                        w_sck_re_nxt = 1'b1;
                    end else begin
                        w_sck_fe_nxt = 1'b1;
                        if (!w_last_bit) begin
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end else begin
                            w_bit_cnt_nxt = '0;
                            if (!r_ws) begin
                                w_ws_nxt = 1'b1;
                            end else begin
                                // Frame boundary: the only point where en_i and config are looked at.
                                w_frame_done_nxt = 1'b1;
                                if (en_i) begin
                                    w_ws_nxt    = 1'b0;
                                    w_div_q_nxt = div_i;
                                    w_chl_q_nxt = chl_i;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_div_q      <= '0;
            r_chl_q      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_sck        <= 1'b0;
            r_ws         <= 1'b1;
            r_sck_re     <= 1'b0;
            r_sck_fe     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_q      <= w_div_q_nxt;
            r_chl_q      <= w_chl_q_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_sck        <= w_sck_nxt;
            r_ws         <= w_ws_nxt;
            r_sck_re     <= w_sck_re_nxt;
            r_sck_fe     <= w_sck_fe_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= (w_state_nxt == ST_RUN);
        end
    end

    assign busy_o       = r_busy;
    assign i2s_sck_o    = r_sck;
    assign i2s_ws_o     = r_ws;
    assign sck_re_o     = r_sck_re;
    assign sck_fe_o     = r_sck_fe;
    assign frame_done_o = r_frame_done;

`ifdef I2S_CLKGEN_FRM_CNT_EN
    logic [15:0] r_frm_cnt;
    logic [15:0] w_frm_cnt_nxt;

    always_comb begin
        w_frm_cnt_nxt = r_frm_cnt;
        if (r_state == ST_IDLE && w_state_nxt == ST_RUN) begin
            w_frm_cnt_nxt = '0;
        end else if (w_frame_done_nxt) begin
            w_frm_cnt_nxt = r_frm_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_frm_cnt <= '0;
        end else begin
            r_frm_cnt <= w_frm_cnt_nxt;
        end
    end

    assign frm_cnt_o = r_frm_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_clkgen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_clkgen_ctrl
//  Purpose  : Randomized scoreboard bench for i2s_clkgen_ctrl; expected SCK/WS
//             edge events are computed per frame from channel length and divider.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_clkgen_ctrl;

    localparam int DIV_WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [DIV_WIDTH-1:0] div;
    logic [1:0]           chl;
    logic                 busy;
    logic                 sck;
    logic                 ws;
    logic                 sck_re;
    logic                 sck_fe;
    logic                 frame_done;
`ifdef I2S_CLKGEN_FRM_CNT_EN
    logic [15:0]          frm_cnt;
`endif

    i2s_clkgen_ctrl #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .div_i        (div),
        .chl_i        (chl),
        .busy_o       (busy),
        .i2s_sck_o    (sck),
        .i2s_ws_o     (ws),
        .sck_re_o     (sck_re),
        .sck_fe_o     (sck_fe),
        .frame_done_o (frame_done)
`ifdef I2S_CLKGEN_FRM_CNT_EN
        ,
        .frm_cnt_o    (frm_cnt)
`endif
    );

    typedef struct {
        int cyc;
        bit re;
        bit fe;
        bit fd;
        bit sck;
        bit ws;
        bit busy;
        bit busy_care;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (sck !== 1'b0 || ws !== 1'b1 || busy !== 1'b0 ||
            sck_re !== 1'b0 || sck_fe !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got sck=%b ws=%b busy=%b re=%b fe=%b fd=%b want sck=0 ws=1 busy=0 re=0 fe=0 fd=0",
                     tag, cyc, sck, ws, busy, sck_re, sck_fe, frame_done);
        end
    endtask

    // One frame starting at cycle s (WS falls in s): 2N SCK periods of 2*(d+1) clocks each.
    function automatic void push_frame(input int s, input int d, input int c, input bit cont);
        int  h;
        int  n;
        ev_t x;
        h = d + 1;
        n = 8 * (c + 1);
        for (int k = 0; k < 2 * n; k++) begin
            x = '{cyc: s + (2*k + 1) * h, re: 1'b1, fe: 1'b0, fd: 1'b0, sck: 1'b1,
                  ws: (k < n) ? 1'b0 : 1'b1, busy: 1'b1, busy_care: 1'b1};
            q.push_back(x);
            x = '{cyc: s + (2*k + 2) * h, re: 1'b0, fe: 1'b1, fd: (k == 2*n - 1), sck: 1'b0,
                  ws: (k < n - 1) ? 1'b0 : ((k < 2*n - 1) ? 1'b1 : !cont),
                  busy: 1'b1, busy_care: (k != 2*n - 1) || cont};
            q.push_back(x);
        end
    endfunction

    // mode 0: inputs quiet mid-frame; 1: random en/div/chl mid-frame and random
    // next-frame config; 2: div/chl switched to 3/3 early in the first frame.
    task automatic run_session(input int nframes, input int d0, input int c0, input int mode);
        int s;
        int d;
        int c;
        int fend;
        bit cont;
        step();
        div = DIV_WIDTH'(d0);
        chl = 2'(c0);
        en  = 1'b1;
        s = cyc + 1;
        d = d0;
        c = c0;
        for (int f = 0; f < nframes; f++) begin
            cont = (f != nframes - 1);
            push_frame(s, d, c, cont);
            fend = s + 32 * (c + 1) * (d + 1);
            while (cyc < fend - 2) begin
                step();
                if (mode == 1) begin
                    if ($urandom_range(0, 3) == 0)  en  = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 15) == 0) div = DIV_WIDTH'($urandom_range(0, 3));
                    if ($urandom_range(0, 15) == 0) chl = 2'($urandom_range(0, 3));
                end else if (mode == 2 && f == 0 && cyc == s + 10) begin
                    div = DIV_WIDTH'(3);
                    chl = 2'd3;
                end
            end
            step();
            en = cont;
            if (mode == 1) begin
                div = DIV_WIDTH'($urandom_range(0, 3));
                chl = 2'($urandom_range(0, 3));
            end
            s = fend;
            d = int'(div);
            c = int'(chl);
        end
        step();
        en = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            step();
            check_idle("idle_after_stop");
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_event cyc=%0d got no event want re=%b fe=%b fd=%b at cyc=%0d",
                         cyc, q[0].re, q[0].fe, q[0].fd, q[0].cyc);
                void'(q.pop_front());
            end
            if (sck_re || sck_fe || frame_done) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event cyc=%0d got re=%b fe=%b fd=%b want no event",
                             cyc, sck_re, sck_fe, frame_done);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || sck_re !== e.re || sck_fe !== e.fe || frame_done !== e.fd ||
                        sck !== e.sck || ws !== e.ws || (e.busy_care && busy !== e.busy)) begin
                        n_errors++;
                        $display("FAIL edge_event got cyc=%0d re=%b fe=%b fd=%b sck=%b ws=%b busy=%b want cyc=%0d re=%b fe=%b fd=%b sck=%b ws=%b busy=%b",
                                 cyc, sck_re, sck_fe, frame_done, sck, ws, busy,
                                 e.cyc, e.re, e.fe, e.fd, e.sck, e.ws, e.busy);
                    end
                end
            end
        end
    end

`ifdef I2S_CLKGEN_FRM_CNT_EN
    task automatic chk_cnt(input string tag, input int exp);
        n_checks++;
        if (frm_cnt !== 16'(exp)) begin
            n_errors++;
            $display("FAIL %s got frm_cnt=%0d want %0d", tag, frm_cnt, exp);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d got no finish want finish", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        div   = '0;
        chl   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_values");
        rst_n = 1'b1;
        repeat (100) begin
            step();
            check_idle("idle_en_low");
        end

        run_session(1, 1, 0, 0);
        run_session(1, 1, 1, 1);
        run_session(2, 1, 0, 2);
        run_session(2, 0, 0, 0);

        // Asynchronous reset in the middle of a frame, checked between clock edges.
        step();
        div = DIV_WIDTH'(1);
        chl = 2'd1;
        en  = 1'b1;
        push_frame(cyc + 1, 1, 1, 1'b1);
        repeat (40) step();
        #1 rst_n = 1'b0;
        #1 check_idle("async_reset");
        q.delete();
        en = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_idle("after_async_reset");

        for (int i = 0; i < 25; i++) begin
            run_session($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1);
        end

`ifdef I2S_CLKGEN_FRM_CNT_EN
        run_session(5, 0, 0, 0);
        chk_cnt("frm_cnt_five", 5);
        fork
            run_session(1, 0, 0, 0);
            begin
                for (int k = 0; k < 10; k++) begin
                    step();
                    if (busy) break;
                end
                chk_cnt("frm_cnt_restart_clear", 0);
                repeat (5) step();
                force dut.r_frm_cnt = 16'hFFFF;
                step();
                release dut.r_frm_cnt;
            end
        join
        chk_cnt("frm_cnt_wrap", 0);
`endif

        repeat (5) step();
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_events got %0d outstanding want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
